// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the byte-lane memory: access sizes,
// FSM states, and byte-enable / store-data steering.
package mem_pkg;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } access_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } mem_state_e;

    function automatic logic [2:0] access_bytes(access_size_e s);
        case (s)
            BYTE:    return 3'd1;
            HALF:    return 3'd2;
            WORD:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic misaligned(access_size_e s, logic [1:0] a);
        case (s)
            HALF:    return a[0];
            WORD:    return (a != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Byte-lane enables for an aligned access; lane n holds address bits [1:0] == n.
    function automatic logic [3:0] lane_mask(access_size_e s, logic [1:0] a);
        case (s)
            BYTE:    return 4'b0001 << a;
            HALF:    return a[1] ? 4'b1100 : 4'b0011;
            WORD:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate right-aligned store data across lanes so the mask alone selects it.
    function automatic logic [31:0] lane_data(access_size_e s, logic [31:0] d);
        case (s)
            BYTE:    return {4{d[7:0]}};
            HALF:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_bank_array.sv
// Four byte-wide banks, one per lane, with independent write enables.
// Reads are combinational from the word index; contents are never reset.
module mem_bank_array #(
    parameter int DEPTH = 16384,
    parameter int IW    = 14
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [IW-1:0] wr_idx,
    input  logic [31:0]   wdata,
    input  logic [IW-1:0] rd_idx,
    output logic [31:0]   rdata
);

    for (genvar lane = 0; lane < 4; lane++) begin : g_lane
        logic [7:0] bank [DEPTH];

        always_ff @(posedge clk) begin
            if (we[lane]) begin
                bank[wr_idx] <= wdata[8*lane +: 8];
            end
        end

        assign rdata[8*lane +: 8] = bank[rd_idx];
    end

endmodule

// File: rtl/byte_lane_memory.sv
// Single-outstanding byte-addressable memory with a fixed wait-state latency,
// alignment/bounds fault checking and little-endian lane steering.
module byte_lane_memory
    import mem_pkg::*;
#(
    parameter int SIZE        = 65536,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [1:0]  dbg_state
);

    // Handshake: a request is accepted on a rising edge where req_valid and
    // req_ready are both 1; req_ready is 1 only in IDLE with reset released,
    // and the master holds the request stable until then.

    localparam int DEPTH = SIZE / 4;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW    = IW + 2;
    localparam logic [2:0]  WS_LAST = 3'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
    localparam logic [32:0] SIZE_33 = 33'(SIZE);

    mem_state_e   state_q, state_d;
    logic [2:0]   wait_cnt_q, wait_cnt_d;
    logic         write_q, write_d;
    logic         signed_q, signed_d;
    logic         fault_q, fault_d;
    access_size_e size_q, size_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]  wdata_q, wdata_d;

    access_size_e req_size_e;
    logic [32:0]  req_end;
    logic         req_fault;
    logic         accept;

    assign req_size_e = access_size_e'(req_size);
    assign req_end    = {1'b0, req_address} + {30'b0, access_bytes(req_size_e)};
    assign req_fault  = (req_size_e == ILLEGAL)
                      || misaligned(req_size_e, req_address[1:0])
                      || (req_end > SIZE_33);

    assign req_ready = (state_q == IDLE) && reset;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        write_d    = write_q;
        signed_d   = signed_q;
        fault_d    = fault_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d    = req_write;
                    signed_d   = req_signed;
                    fault_d    = req_fault;
                    size_d     = req_size_e;
                    addr_d     = req_address[AW-1:0];
                    wdata_d    = req_wdata;
                    wait_cnt_d = 3'd0;
                    state_d    = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q == WS_LAST) begin
                    wait_cnt_d = 3'd0;
                    state_d    = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= 3'd0;
            write_q    <= 1'b0;
            signed_q   <= 1'b0;
            fault_q    <= 1'b0;
            size_q     <= BYTE;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            write_q    <= write_d;
            signed_q   <= signed_d;
            fault_q    <= fault_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // With zero wait states the commit edge is the accept edge itself, so the
    // store is steered from the live request rather than the latched copy.
    logic          from_req;
    logic          cmt_write, cmt_fault, enter_resp;
    access_size_e  cmt_size;
    logic [AW-1:0] cmt_addr;
    logic [31:0]   cmt_wdata;
    logic [3:0]    bank_we;
    logic [31:0]   bank_wdata;
    logic [31:0]   rword;

    assign from_req   = (state_q == IDLE);
    assign cmt_write  = from_req ? req_write : write_q;
    assign cmt_fault  = from_req ? req_fault : fault_q;
    assign cmt_size   = from_req ? req_size_e : size_q;
    assign cmt_addr   = from_req ? req_address[AW-1:0] : addr_q;
    assign cmt_wdata  = from_req ? req_wdata : wdata_q;
    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    assign bank_we    = (enter_resp && cmt_write && !cmt_fault && reset)
                      ? lane_mask(cmt_size, cmt_addr[1:0]) : 4'b0000;
    assign bank_wdata = lane_data(cmt_size, cmt_wdata);

    mem_bank_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_banks (
        .clk    (clk),
        .we     (bank_we),
        .wr_idx (cmt_addr[AW-1:2]),
        .wdata  (bank_wdata),
        .rd_idx (addr_q[AW-1:2]),
        .rdata  (rword)
    );

    logic [7:0]  load_b;
    logic [15:0] load_h;
    logic [31:0] load_data;

    always_comb begin
        load_b    = rword[8*addr_q[1:0] +: 8];
        load_h    = addr_q[1] ? rword[31:16] : rword[15:0];
        load_data = 32'd0;
        case (size_q)
            BYTE:    load_data = {{24{signed_q & load_b[7]}}, load_b};
            HALF:    load_data = {{16{signed_q & load_h[15]}}, load_h};
            WORD:    load_data = rword;
            default: load_data = 32'd0;
        endcase
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_fault = rsp_valid && fault_q;
    assign rsp_rdata = (rsp_valid && !write_q && !fault_q) ? load_data : 32'd0;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_byte_lane_memory.sv
// Directed bench for byte_lane_memory: three instances with WAIT_STATES 1, 0
// and 3 share one clock; each transaction is checked for latency and data.
module tb_byte_lane_memory;
    import mem_pkg::*;

    localparam int SZ = 1024;
    localparam int WS_TAB [3] = '{1, 0, 3};

    logic        clk;
    logic        reset_a     [3];
    logic        req_valid_a [3];
    logic        req_ready_a [3];
    logic        req_write_a [3];
    logic [1:0]  req_size_a  [3];
    logic        req_signed_a[3];
    logic [31:0] req_addr_a  [3];
    logic [31:0] req_wdata_a [3];
    logic        rsp_valid_a [3];
    logic [31:0] rsp_rdata_a [3];
    logic        rsp_fault_a [3];
    logic [1:0]  dbg_state_a [3];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        byte_lane_memory #(
            .SIZE        (SZ),
            .WAIT_STATES ((g == 0) ? 1 : (g == 1) ? 0 : 3)
        ) u_dut (
            .clk         (clk),
            .reset       (reset_a[g]),
            .req_valid   (req_valid_a[g]),
            .req_ready   (req_ready_a[g]),
            .req_write   (req_write_a[g]),
            .req_size    (req_size_a[g]),
            .req_signed  (req_signed_a[g]),
            .req_address (req_addr_a[g]),
            .req_wdata   (req_wdata_a[g]),
            .rsp_valid   (rsp_valid_a[g]),
            .rsp_rdata   (rsp_rdata_a[g]),
            .rsp_fault   (rsp_fault_a[g]),
            .dbg_state   (dbg_state_a[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request on instance d and check latency, data, fault and pulse width.
    task automatic txn(input int d, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input logic exp_fault, input string tag);
        int n;
        @(negedge clk);
        req_write_a[d]  = wr;
        req_size_a[d]   = sz;
        req_signed_a[d] = sg;
        req_addr_a[d]   = addr;
        req_wdata_a[d]  = wd;
        req_valid_a[d]  = 1'b1;
        n = 0;
        while (!req_ready_a[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid_a[d] = 1'b0;
        n = 0;
        while (!rsp_valid_a[d] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n + 1), 32'(WS_TAB[d] + 1));
        check({tag, "_rdata"}, rsp_rdata_a[d], exp_rdata);
        check({tag, "_fault"}, {31'b0, rsp_fault_a[d]}, {31'b0, exp_fault});
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {31'b0, rsp_valid_a[d]}, 32'd0);
    endtask

    initial begin
        int accepts;
        int seen;
        for (int d = 0; d < 3; d++) begin
            reset_a[d]      = 1'b0;
            req_valid_a[d]  = 1'b0;
            req_write_a[d]  = 1'b0;
            req_size_a[d]   = 2'b00;
            req_signed_a[d] = 1'b0;
            req_addr_a[d]   = 32'd0;
            req_wdata_a[d]  = 32'd0;
        end
        #12;
        for (int d = 0; d < 3; d++) begin
            check("rst_valid", {31'b0, rsp_valid_a[d]}, 32'd0);
            check("rst_rdata", rsp_rdata_a[d], 32'd0);
            check("rst_state", {30'b0, dbg_state_a[d]}, {30'b0, IDLE});
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) reset_a[d] = 1'b1;
        #1;
        check("rst_ready", {31'b0, req_ready_a[0]}, 32'd1);

        // Word store / load round trip
        txn(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "st_w10");
        txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld_w10");

        // Byte store into the top lane, then sign/zero-extended reads
        txn(0, 1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFF80, 32'h0, 1'b0, "st_b13");
        txn(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, "ld_sb13");
        txn(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h00000080, 1'b0, "ld_ub13");
        txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, "ld_w10b");
        txn(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF80AD, 1'b0, "ld_sh12");
        txn(0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, "ld_uh10");
        txn(0, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, "ld_sw10");
        txn(0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0, "ld_sb11");

        // Halfword store touches only its two lanes
        txn(0, 1'b1, 2'b10, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, "st_w14");
        txn(0, 1'b1, 2'b01, 1'b0, 32'h16, 32'h1234A5B6, 32'h0, 1'b0, "st_h16");
        txn(0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'hA5B60000, 1'b0, "ld_w14");

        // Faults, then confirm memory untouched
        txn(0, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, "f_h11");
        txn(0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h11223344, 32'h0, 1'b1, "f_sw12");
        txn(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, "f_ill");
        txn(0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h55555555, 32'h0, 1'b1, "f_st_ill");
        txn(0, 1'b0, 2'b10, 1'b0, 32'(SZ - 2), 32'h0, 32'h0, 1'b1, "f_end");
        txn(0, 1'b0, 2'b01, 1'b0, 32'(SZ), 32'h0, 32'h0, 1'b1, "f_oob");
        txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, "ld_w10c");

        // Last legal word and byte in the array
        txn(0, 1'b1, 2'b10, 1'b0, 32'(SZ - 4), 32'hA1B2C3D4, 32'h0, 1'b0, "st_last");
        txn(0, 1'b0, 2'b00, 1'b0, 32'(SZ - 1), 32'h0, 32'h000000A1, 1'b0, "ld_lastb");

        // Zero wait states: functional round trip, then back-to-back requests
        txn(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0BADCAFE, 32'h0, 1'b0, "ws0_st");
        txn(1, 1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 32'h00000BAD, 1'b0, "ws0_ld");
        @(negedge clk);
        req_write_a[1]  = 1'b0;
        req_size_a[1]   = 2'b10;
        req_signed_a[1] = 1'b0;
        req_addr_a[1]   = 32'h40;
        req_valid_a[1]  = 1'b1;
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            check("b2b_ready", {31'b0, req_ready_a[1]}, {31'b0, (i % 2 == 0)});
            check("b2b_rsp", {31'b0, rsp_valid_a[1]}, {31'b0, (i % 2 == 1)});
            if (rsp_valid_a[1]) check("b2b_data", rsp_rdata_a[1], 32'h0BADCAFE);
            if (req_ready_a[1]) accepts++;
            @(negedge clk);
        end
        req_valid_a[1] = 1'b0;
        check("b2b_accepts", 32'(accepts), 32'd4);

        // Reset during WAIT aborts an uncommitted store
        txn(2, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, "ws3_st");
        txn(2, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "ws3_ld");
        @(negedge clk);
        req_write_a[2] = 1'b1;
        req_size_a[2]  = 2'b10;
        req_addr_a[2]  = 32'h20;
        req_wdata_a[2] = 32'h12345678;
        req_valid_a[2] = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a[2] = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_wait", {30'b0, dbg_state_a[2]}, {30'b0, WAIT});
        reset_a[2] = 1'b0;
        #1;
        check("abort_state", {30'b0, dbg_state_a[2]}, {30'b0, IDLE});
        check("abort_valid", {31'b0, rsp_valid_a[2]}, 32'd0);
        check("abort_rdata", rsp_rdata_a[2], 32'd0);
        check("abort_fault", {31'b0, rsp_fault_a[2]}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_a[2] = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid_a[2]) seen++;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);
        check("abort_ready", {31'b0, req_ready_a[2]}, 32'd1);
        txn(2, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "abort_ld");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
